// File: rtl/mapper_pkg.sv
// Shared types for the cartridge mapper memory responder.
// Holds the responder FSM encoding and the open-bus read value.
package mapper_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SD_REQ,
    HIT,
    BR_RD,
    BR_WR,
    DONE
  } resp_state_t;

  localparam logic [7:0] RD_OPEN_BUS = 8'hFF;

  // Only the SDRAM wait and the BRAM read-capture cycle hold the CPU;
  // HIT and BR_WR already have their result, so they complete the access themselves.
  function automatic logic is_stall_state(input resp_state_t s);
    return (s == SD_REQ) || (s == BR_RD);
  endfunction

endpackage

// File: rtl/mapper_resp_cache.sv
// Single-entry last-read cache for ROM bytes: combinational lookup, registered fill/flush.
// Flush wins over a same-cycle fill; reset leaves the entry invalid.
module mapper_resp_cache
  import mapper_pkg::*;
#(
  parameter int ADDR_W = 27
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_fill,
  input  logic [ADDR_W-1:0] i_fill_addr,
  input  logic [7:0]        i_fill_data,
  input  logic [ADDR_W-1:0] i_lookup_addr,
  output logic              o_hit,
  output logic [7:0]        o_data
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_tag;
  logic [7:0]        r_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= RD_OPEN_BUS;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_tag   <= i_fill_addr;
      r_data  <= i_fill_data;
    end
  end

  assign o_hit  = r_valid && (r_tag == i_lookup_addr);
  assign o_data = r_data;

endmodule

// File: rtl/mapper_mem_responder.sv
// Serves mapper-translated CPU accesses from SDRAM (ROM, 1-entry cache) or BRAM (save RAM).
// Stall is wait_n low from accept until the result is ready; SDRAM reads abort after TIMEOUT cycles.
module mapper_mem_responder
  import mapper_pkg::*;
#(
  parameter int ADDR_W  = 27,
  parameter int SRAM_AW = 17,
  parameter int TIMEOUT = 64
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_req,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic               i_ram_cs,
  input  logic               i_sram_cs,
  input  logic               i_rnw,
  input  logic [7:0]         i_wr_data,
  output logic [7:0]         o_rd_data,
  output logic               o_wait_n,
  input  logic               i_cache_flush,
  input  logic               i_dirty_clr,
  output logic               o_sram_dirty,
  output logic               o_timeout_err,
  output logic               o_sdram_req,
  output logic [ADDR_W-1:0]  o_sdram_addr,
  input  logic               i_sdram_ack,
  input  logic [7:0]         i_sdram_dout,
  output logic [SRAM_AW-1:0] o_bram_addr,
  output logic               o_bram_we,
  output logic [7:0]         o_bram_din,
  input  logic [7:0]         i_bram_q
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  resp_state_t       r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic [7:0]        r_rd_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_flush_pend;
  logic              r_sdram_req;
  logic              r_bram_we;
  logic              r_dirty;
  logic              r_timeout_err;

  logic              w_idle;
  logic              w_accept;
  logic              w_open_bus;
  logic              w_hit;
  logic              w_fill;
  logic [7:0]        w_cache_data;

  assign w_idle     = (r_state == IDLE);
  assign w_accept   = !i_reset && i_req && w_idle && (i_ram_cs || i_sram_cs);
  assign w_open_bus = !i_reset && i_req && w_idle && !(i_ram_cs || i_sram_cs);
  // A flush seen while the read was outstanding means this fill may be stale.
  assign w_fill     = (r_state == SD_REQ) && i_sdram_ack && !r_flush_pend;

  mapper_resp_cache #(
    .ADDR_W (ADDR_W)
  ) u_cache (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_flush       (i_cache_flush),
    .i_fill        (w_fill),
    .i_fill_addr   (r_addr),
    .i_fill_data   (i_sdram_dout),
    .i_lookup_addr (i_addr),
    .o_hit         (w_hit),
    .o_data        (w_cache_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rd_data     <= RD_OPEN_BUS;
      r_cnt         <= '0;
      r_flush_pend  <= 1'b0;
      r_sdram_req   <= 1'b0;
      r_bram_we     <= 1'b0;
      r_dirty       <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_bram_we     <= 1'b0;
      r_timeout_err <= 1'b0;
      if (i_cache_flush && (r_state == SD_REQ)) r_flush_pend <= 1'b1;
      if (r_state == BR_WR)  r_dirty <= 1'b1;
      else if (i_dirty_clr)  r_dirty <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr       <= i_addr;
            r_wdata      <= i_wr_data;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            if (i_sram_cs) begin
              if (i_rnw) begin
                r_state <= BR_RD;
              end else begin
                r_state   <= BR_WR;
                r_bram_we <= 1'b1;
              end
            end else if (w_hit) begin
              r_state   <= HIT;
              r_rd_data <= w_cache_data;
            end else begin
              r_state     <= SD_REQ;
              r_sdram_req <= 1'b1;
            end
          end
        end
        SD_REQ: begin
          if (i_sdram_ack) begin
            r_rd_data   <= i_sdram_dout;
            r_sdram_req <= 1'b0;
            r_state     <= DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_rd_data     <= RD_OPEN_BUS;
            r_timeout_err <= 1'b1;
            r_sdram_req   <= 1'b0;
            r_state       <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        BR_RD: begin
          r_rd_data <= i_bram_q;
          r_state   <= DONE;
        end
        HIT, BR_WR, DONE: r_state <= IDLE;
        default:          r_state <= IDLE;
      endcase
    end
  end

  assign o_wait_n      = !(w_accept || is_stall_state(r_state));
  assign o_rd_data     = w_open_bus ? RD_OPEN_BUS : r_rd_data;
  assign o_sram_dirty  = r_dirty;
  assign o_timeout_err = r_timeout_err;
  assign o_sdram_req   = r_sdram_req;
  assign o_sdram_addr  = r_addr;
  // The accept-cycle address goes straight to the BRAM so its data is ready in BR_RD.
  assign o_bram_addr   = w_idle ? i_addr[SRAM_AW-1:0] : r_addr[SRAM_AW-1:0];
  assign o_bram_we     = r_bram_we;
  assign o_bram_din    = r_wdata;

`ifndef SYNTHESIS
  a_req_only_in_idle: assert property (@(posedge i_clk) disable iff (i_reset) !(i_req && !w_idle));
`endif

endmodule
